// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the multi-channel PWM block.
// Mode and direction encodings are used by the timebase and its users.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // $clog2 that never returns zero, so 1-deep counters still get a bit
  function automatic int CNT_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Control/output bundle between the pattern sequencer and the PWM block.
// Signal names mirror the io_* port list of the block.
interface pwm_multi_channel_if
  import pwm_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DUTY_WIDTH = 7
);
  localparam int CH_W = CNT_W(CHANNELS);

  logic                  wrEn;
  logic [CH_W-1:0]       wrChan;
  logic [DUTY_WIDTH-1:0] wrDuty;
  logic [CHANNELS-1:0]   enable;
  logic [CHANNELS-1:0]   invert;
  logic                  centerMode;
  logic                  periodStart;
  logic [CHANNELS-1:0]   pwmOut;

  modport master (
    output wrEn, wrChan, wrDuty,
    output enable, invert, centerMode,
    input  periodStart, pwmOut
  );

  modport slave (
    input  wrEn, wrChan, wrDuty,
    input  enable, invert, centerMode,
    output periodStart, pwmOut
  );

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/centre counter, wrap pulse.
// Mode is latched only at wrap so a period never changes shape midway.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PERIOD   = 100,
  parameter int PRESCALE = 1,
  parameter int OUT_W    = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             center_i,
  output logic [OUT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             start_o
);

  localparam int CW = CNT_W(PERIOD);
  localparam int PW = CNT_W(PRESCALE);
  localparam logic [CW-1:0] TOP  = CW'(PERIOD - 1);
  localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         mode_q, mode_d;
  dir_e          dir_q, dir_d;
  logic          start_q;
  logic          tick;

  assign tick = (pre_q == PTOP);

  always_comb begin
    pre_d  = tick ? '0 : pre_q + 1'b1;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    wrap_o = 1'b0;
    if (tick) begin
      unique case (1'b1)
        mode_q == PWM_EDGE:
          cnt_d = (cnt_q == TOP) ? '0 : cnt_q + 1'b1;
        mode_q == PWM_CENTER && dir_q == DIR_UP:
          if (cnt_q == TOP) begin
            cnt_d = cnt_q - 1'b1;
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        default:
          cnt_d = cnt_q - 1'b1;
      endcase
      wrap_o = (cnt_d == '0);
    end
    if (wrap_o) begin
      mode_d = mode_e'(center_i);
      dir_d  = DIR_UP;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= PWM_EDGE;
      dir_q   <= DIR_UP;
      start_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      start_q <= wrap_o;
    end
  end

  assign cnt_o   = OUT_W'(cnt_q);
  assign start_o = start_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: double-buffered duty, per-channel enable/polarity.
// Shadow duty moves to active only at wrap so updates never glitch.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DUTY_WIDTH = 7,
  parameter int PERIOD     = 100,
  parameter int PRESCALE   = 1
) (
  input logic                clock,
  input logic                reset,
  pwm_multi_channel_if.slave io
);

  localparam int CH_W = CNT_W(CHANNELS);
  localparam logic [DUTY_WIDTH-1:0] DMAX = DUTY_WIDTH'(PERIOD);
  localparam logic [CH_W:0]         NCH  = (CH_W + 1)'(CHANNELS);

  logic [DUTY_WIDTH-1:0] shadow_q [CHANNELS];
  logic [DUTY_WIDTH-1:0] shadow_d [CHANNELS];
  logic [DUTY_WIDTH-1:0] active_q [CHANNELS];
  logic [DUTY_WIDTH-1:0] active_d [CHANNELS];
  logic [CHANNELS-1:0]   pwm_q, pwm_d;
  logic [DUTY_WIDTH-1:0] cnt;
  logic [DUTY_WIDTH-1:0] wr_val;
  logic                  wr_hit;
  logic                  wrap;
  logic                  start;

  pwm_timebase #(
    .PERIOD   (PERIOD),
    .PRESCALE (PRESCALE),
    .OUT_W    (DUTY_WIDTH)
  ) u_timebase (
    .clock    (clock),
    .reset    (reset),
    .center_i (io.centerMode),
    .cnt_o    (cnt),
    .wrap_o   (wrap),
    .start_o  (start)
  );

  assign wr_val = (io.wrDuty > DMAX) ? DMAX : io.wrDuty;
  assign wr_hit = io.wrEn && ({1'b0, io.wrChan} < NCH);

  // Active takes the pre-write shadow when a write lands on a wrap
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = wrap ? shadow_q[i] : active_q[i];
      if (wr_hit && io.wrChan == CH_W'(i)) shadow_d[i] = wr_val;
      pwm_d[i] = (io.enable[i] && (cnt < active_q[i])) ^ io.invert[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      pwm_q <= pwm_d;
    end
  end

  assign io.pwmOut      = pwm_q;
  assign io.periodStart = start;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: A = 4ch/prescale 1, B = 3ch/prescale 4.
// Both see the same stimulus; each has its own phase-based reference model.
module tb_pwm_multi_channel;

  localparam int P = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  bit       rst = 1'b1;
  bit       wen = 1'b0;
  int       wch = 0;
  int       wdu = 0;
  bit [3:0] en  = '0;
  bit [3:0] inv = '0;
  bit       cen = 1'b0;

  int total = 0;
  int bad   = 0;

  pwm_multi_channel_if #(.CHANNELS(4), .DUTY_WIDTH(7)) ia ();
  pwm_multi_channel_if #(.CHANNELS(3), .DUTY_WIDTH(7)) ib ();

  assign ia.wrEn       = wen;
  assign ia.wrChan     = 2'(wch);
  assign ia.wrDuty     = 7'(wdu);
  assign ia.enable     = en;
  assign ia.invert     = inv;
  assign ia.centerMode = cen;
  assign ib.wrEn       = wen;
  assign ib.wrChan     = 2'(wch);
  assign ib.wrDuty     = 7'(wdu);
  assign ib.enable     = en[2:0];
  assign ib.invert     = inv[2:0];
  assign ib.centerMode = cen;

  pwm_multi_channel #(
    .CHANNELS(4), .DUTY_WIDTH(7), .PERIOD(P), .PRESCALE(1)
  ) dut_a (
    .clock (clk),
    .reset (rst),
    .io    (ia)
  );

  pwm_multi_channel #(
    .CHANNELS(3), .DUTY_WIDTH(7), .PERIOD(P), .PRESCALE(4)
  ) dut_b (
    .clock (clk),
    .reset (rst),
    .io    (ib)
  );

  // Reference model: phase within period, cnt derived arithmetically
  int       CHN [2] = '{4, 3};
  int       PSC [2] = '{1, 4};
  int       ph  [2];
  int       pre [2];
  bit       md  [2];
  int       sh  [2][4];
  int       ac  [2][4];
  logic [3:0] ep [2];
  logic       es [2];

  task automatic model_step(input int k);
    int  plen;
    int  c;
    bit  tick;
    bit  wrap;
    if (rst) begin
      ph[k] = 0; pre[k] = 0; md[k] = 0;
      for (int i = 0; i < 4; i++) begin
        sh[k][i] = 0; ac[k][i] = 0;
      end
      ep[k] = '0; es[k] = 1'b0;
      return;
    end
    plen = md[k] ? 2 * (P - 1) : P;
    c = (md[k] && ph[k] >= P) ? plen - ph[k] : ph[k];
    ep[k] = '0;
    for (int i = 0; i < CHN[k]; i++)
      ep[k][i] = (en[i] && (c < ac[k][i])) ^ inv[i];
    tick = (pre[k] == PSC[k] - 1);
    pre[k] = tick ? 0 : pre[k] + 1;
    wrap = 1'b0;
    if (tick) begin
      ph[k] = ph[k] + 1;
      if (ph[k] == plen) begin
        ph[k] = 0;
        wrap = 1'b1;
      end
    end
    if (wrap) begin
      for (int i = 0; i < 4; i++) ac[k][i] = sh[k][i];
      md[k] = cen;
    end
    es[k] = wrap;
    if (wen && wch < CHN[k]) sh[k][wch] = (wdu > P) ? P : wdu;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    total++;
    if (ia.pwmOut !== ep[0] || ia.periodStart !== es[0]) begin
      bad++;
      $display("FAIL model_a t=%0t pwm=%b ps=%b want pwm=%b ps=%b",
               $time, ia.pwmOut, ia.periodStart, ep[0], es[0]);
    end
    total++;
    if (ib.pwmOut !== ep[1][2:0] || ib.periodStart !== es[1]) begin
      bad++;
      $display("FAIL model_b t=%0t pwm=%b ps=%b want pwm=%b ps=%b",
               $time, ib.pwmOut, ib.periodStart, ep[1][2:0], es[1]);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic logic ps_of(input int k);
    return (k == 0) ? ia.periodStart : ib.periodStart;
  endfunction

  function automatic logic pwm_of(input int k, input int ch);
    return (k == 0) ? ia.pwmOut[ch] : ib.pwmOut[ch];
  endfunction

  // Bounded wait for the next period pulse; returns cycles waited
  task automatic wait_ps(input int k, input int lim, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ps_of(k) && n < lim);
    if (!ps_of(k)) begin
      bad++;
      $display("FAIL timeout_ps k=%0d got=none want=pulse", k);
    end
  endtask

  // From a pulse sample: count high samples of ch until the next pulse
  task automatic measure(input int k, input int ch, output int n,
                         output int hi);
    n = 0;
    hi = 0;
    do begin
      hi += int'(pwm_of(k, ch));
      cyc();
      n++;
    end while (!ps_of(k) && n < 2000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wen = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic write(input int ch, input int d);
    wen = 1'b1;
    wch = ch;
    wdu = d;
    cyc();
    wen = 1'b0;
  endtask

  typedef struct {
    int ch;
    int duty;
    bit center;
    bit inv;
    int plen;
    int high;
  } vec_t;

  vec_t vt [8];

  initial begin
    int n;
    int hi;
    int lo;

    vt[0] = '{0, 25, 1'b0, 1'b0, 100, 25};
    vt[1] = '{1, 0, 1'b0, 1'b0, 100, 0};
    vt[2] = '{2, 100, 1'b0, 1'b0, 100, 100};
    vt[3] = '{3, 127, 1'b0, 1'b0, 100, 100};
    vt[4] = '{0, 50, 1'b1, 1'b0, 198, 99};
    vt[5] = '{1, 1, 1'b1, 1'b0, 198, 1};
    vt[6] = '{2, 100, 1'b1, 1'b0, 198, 198};
    vt[7] = '{0, 10, 1'b0, 1'b1, 100, 90};

    do_reset();
    chk("reset_pwm_a", int'(ia.pwmOut), 0);
    chk("reset_ps_a", int'(ia.periodStart), 0);
    chk("reset_pwm_b", int'(ib.pwmOut), 0);

    foreach (vt[v]) begin
      do_reset();
      en  = 4'(1 << vt[v].ch);
      inv = 4'(int'(vt[v].inv) << vt[v].ch);
      cen = vt[v].center;
      write(vt[v].ch, vt[v].duty);
      n = 1;
      begin
        int m;
        wait_ps(0, 500, m);
        n += m;
      end
      chk($sformatf("first_wrap_v%0d", v), n, 100);
      wait_ps(0, 500, n);
      measure(0, vt[v].ch, n, hi);
      chk($sformatf("period_v%0d", v), n, vt[v].plen);
      chk($sformatf("high_v%0d", v), hi, vt[v].high);
      for (int c = 0; c < 4; c++)
        if (c != vt[v].ch)
          chk($sformatf("idle_v%0d_c%0d", v, c), int'(ia.pwmOut[c]), 0);
    end

    // Mid-period shadow write must not disturb the running period
    do_reset();
    en = 4'b0001; inv = '0; cen = 1'b0;
    write(0, 25);
    wait_ps(0, 500, n);
    wait_ps(0, 500, n);
    for (int i = 0; i < 40; i++) cyc();
    write(0, 60);
    hi = 0;
    n = 0;
    do begin
      hi += int'(ia.pwmOut[0]);
      cyc();
      n++;
    end while (!ia.periodStart && n < 500);
    chk("midwrite_rest", hi, 0);
    measure(0, 0, n, hi);
    chk("midwrite_next", hi, 60);

    // Prescaled inverted channel, out-of-range channel, reset mid-period
    do_reset();
    en = 4'b1111; inv = 4'b0001; cen = 1'b0;
    write(0, 10);
    write(3, 50);
    wait_ps(1, 1000, n);
    wait_ps(1, 1000, n);
    measure(1, 0, n, hi);
    chk("presc_period", n, 400);
    chk("presc_low", n - hi, 40);
    measure(1, 2, n, hi);
    chk("oob_b_ch2", hi, 0);
    for (int i = 0; i < 150; i++) cyc();
    rst = 1'b1;
    cyc();
    chk("midreset_a", int'(ia.pwmOut), 0);
    chk("midreset_b", int'(ib.pwmOut), 0);
    rst = 1'b0;
    cyc();
    chk("postreset_b0", int'(ib.pwmOut[0]), 1);
    wait_ps(1, 1000, n);
    measure(1, 0, n, hi);
    lo = n - hi;
    chk("no_stale_duty", lo, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      wen = ($urandom_range(3) == 0);
      wch = $urandom_range(3);
      wdu = $urandom_range(127);
      if ($urandom_range(49) == 0) en  = 4'($urandom);
      if ($urandom_range(49) == 0) inv = 4'($urandom);
      if ($urandom_range(99) == 0) cen = ~cen;
      rst = ($urandom_range(999) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
